// File: rtl/usb_pkg.sv
// Shared constants and types for the USB full-speed TX packet path.
package usb_pkg;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Number of SE0 bit periods at the start of EOP; one J bit follows.
    localparam int unsigned EOP_SE0_BITS = 2;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        DATA,
        CRC,
        EOP
    } tx_state_t;

    // True for PIDs whose packets carry a payload and CRC16.
    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Bit-period timer: counts clocks within a USB bit and flags the last one.
module usb_tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // Counter wraps every bit period; tick is registered one count early so it
    // is high exactly while the count sits at its last value.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_clear || !i_enable) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
            r_tick <= (r_cnt == CNT_PRE_LAST);
        end
    end

    assign o_bit_tick = r_tick;

endmodule

// File: rtl/usb_tx_packet_serializer.sv
// USB full-speed TX serializer: SYNC, PID, payload and CRC16 as a timed bit stream.
module usb_tx_packet_serializer
    import usb_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned MAX_BYTES    = 64
) (
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic                                i_tx_start,
    input  logic [3:0]                          i_tx_pid,
    input  logic [$clog2(MAX_BYTES + 1)-1:0]    i_tx_byte_count,
    input  logic [7:0]                          i_fifo_data,
    input  logic                                i_fifo_empty,
    output logic                                o_fifo_get_c,
    input  logic [15:0]                         i_crc_in,
    output logic                                o_crc_clear_c,
    output logic                                o_crc_enable,
    output logic                                o_crc_invert,
    output logic                                o_serial_out,
    output logic                                o_bit_tick,
    output logic                                o_eop,
    output logic                                o_tx_busy,
    output logic                                o_tx_done,
    output logic                                o_tx_error_c
);

    localparam int unsigned BYTE_W   = $clog2(MAX_BYTES + 1);
    localparam logic [3:0]  SE0_LAST = 4'(EOP_SE0_BITS - 1);
    localparam logic [3:0]  J_IDX    = 4'(EOP_SE0_BITS);

    tx_state_t          r_state,      w_state_nxt;
    logic [7:0]         r_shift,      w_shift_nxt;
    logic [3:0]         r_bit_idx,    w_bit_idx_nxt;
    logic [BYTE_W-1:0]  r_bytes_left, w_bytes_left_nxt;
    logic [3:0]         r_pid,        w_pid_nxt;
    logic               r_serial,     w_serial_nxt;
    logic               r_eop,        w_eop_nxt;
    logic               r_busy,       w_busy_nxt;
    logic               r_done,       w_done_nxt;
    logic               r_crc_en,     w_crc_en_nxt;
    logic               r_crc_inv,    w_crc_inv_nxt;

    logic               w_accept;
    logic               w_fetch;
    logic               w_underflow;
    logic               w_tick;
    logic               w_crc_bit;

    usb_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_clear    (w_accept),
        .i_enable   (r_state != IDLE),
        .o_bit_tick (w_tick)
    );

    assign w_crc_bit = i_crc_in[4'd15 - r_bit_idx];

    // State and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_bytes_left <= '0;
            r_pid        <= '0;
            r_serial     <= 1'b1;
            r_eop        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_crc_en     <= 1'b0;
            r_crc_inv    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_bytes_left <= w_bytes_left_nxt;
            r_pid        <= w_pid_nxt;
            r_serial     <= w_serial_nxt;
            r_eop        <= w_eop_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_crc_en     <= w_crc_en_nxt;
            r_crc_inv    <= w_crc_inv_nxt;
        end
    end

    // Next-state, field sequencing and per-bit serial value.
    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_bit_idx_nxt    = r_bit_idx;
        w_bytes_left_nxt = r_bytes_left;
        w_pid_nxt        = r_pid;
        w_serial_nxt     = r_serial;
        w_eop_nxt        = r_eop;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_crc_en_nxt     = r_crc_en;
        w_crc_inv_nxt    = 1'b0;
        w_accept         = 1'b0;
        w_fetch          = 1'b0;
        w_underflow      = 1'b0;

        unique case (r_state)
            IDLE: begin
                // A start on the tx_done cycle is dropped.
                if (i_tx_start && !r_done) begin
                    w_accept         = 1'b1;
                    w_state_nxt      = SYNC;
                    w_shift_nxt      = SYNC_BYTE;
                    w_serial_nxt     = SYNC_BYTE[0];
                    w_bit_idx_nxt    = '0;
                    w_pid_nxt        = i_tx_pid;
                    w_bytes_left_nxt = i_tx_byte_count;
                    w_busy_nxt       = 1'b1;
                end
            end

            SYNC: begin
                if (w_tick) begin
                    if (r_bit_idx == 4'd7) begin
                        w_state_nxt   = PID;
                        w_shift_nxt   = {~r_pid, r_pid};
                        w_serial_nxt  = r_pid[0];
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_serial_nxt  = r_shift[1];
                        w_bit_idx_nxt = r_bit_idx + 4'd1;
                    end
                end
            end

            PID, DATA: begin
                if (w_tick) begin
                    if (r_bit_idx != 4'd7) begin
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_serial_nxt  = r_shift[1];
                        w_bit_idx_nxt = r_bit_idx + 4'd1;
                    end else if (r_state == PID && !is_data_pid(r_pid)) begin
                        w_state_nxt   = EOP;
                        w_eop_nxt     = 1'b1;
                        w_serial_nxt  = 1'b1;
                        w_bit_idx_nxt = '0;
                    end else if (r_bytes_left == '0) begin
                        w_state_nxt   = CRC;
                        w_crc_en_nxt  = 1'b0;
                        w_crc_inv_nxt = 1'b1;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_fetch = 1'b1;
                        if (i_fifo_empty) begin
                            w_underflow   = 1'b1;
                            w_state_nxt   = EOP;
                            w_eop_nxt     = 1'b1;
                            w_serial_nxt  = 1'b1;
                            w_crc_en_nxt  = 1'b0;
                            w_bit_idx_nxt = '0;
                        end else begin
                            w_state_nxt      = DATA;
                            w_shift_nxt      = i_fifo_data;
                            w_serial_nxt     = i_fifo_data[0];
                            w_bytes_left_nxt = r_bytes_left - BYTE_W'(1);
                            w_crc_en_nxt     = 1'b1;
                            w_bit_idx_nxt    = '0;
                        end
                    end
                end
            end

            CRC: begin
                // During the invert clock crc_in still holds the raw remainder.
                w_serial_nxt = r_crc_inv ? ~w_crc_bit : w_crc_bit;
                if (w_tick) begin
                    if (r_bit_idx == 4'd15) begin
                        w_state_nxt   = EOP;
                        w_eop_nxt     = 1'b1;
                        w_serial_nxt  = 1'b1;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 4'd1;
                    end
                end
            end

            EOP: begin
                if (w_tick) begin
                    if (r_bit_idx == J_IDX) begin
                        w_state_nxt   = IDLE;
                        w_busy_nxt    = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_serial_nxt  = 1'b1;
                        w_bit_idx_nxt = '0;
                    end else begin
                        if (r_bit_idx == SE0_LAST) begin
                            w_eop_nxt = 1'b0;
                        end
                        w_bit_idx_nxt = r_bit_idx + 4'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_crc_clear_c = w_accept;
    assign o_fifo_get_c  = w_fetch && !i_fifo_empty;
    assign o_tx_error_c  = w_underflow;
    assign o_crc_enable  = r_crc_en;
    assign o_crc_invert  = r_crc_inv;
    assign o_serial_out  = r_serial;
    assign o_bit_tick    = w_tick;
    assign o_eop         = r_eop;
    assign o_tx_busy     = r_busy;
    assign o_tx_done     = r_done;

endmodule

// File: tb/tb_usb_tx_packet_serializer.sv
// Directed bench for usb_tx_packet_serializer with FIFO and CRC16 generator models.
module tb_usb_tx_packet_serializer;

    localparam int CPB = 8;

    typedef struct packed {
        logic eop;
        logic ser;
        logic chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        tx_start;
    logic [3:0]  tx_pid;
    logic [6:0]  tx_byte_count;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_get;
    logic [15:0] crc_in;
    logic        crc_clear;
    logic        crc_enable;
    logic        crc_invert;
    logic        serial_out;
    logic        bit_tick;
    logic        eop;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_error;

    int total = 0;
    int bad   = 0;

    exp_t exp_q[$];

    logic [7:0] fifo_mem [0:15];
    int         fifo_wr = 0;
    int         fifo_rd = 0;
    logic [15:0] crc_rem;

    logic rx_mem [0:1023];
    int   rx_n = 0;
    int   rx_base;

    int n_get, n_cen, n_ctick, n_inv, n_err, n_err_tick, n_done;
    int edges;

    always #5 clk = ~clk;

    usb_tx_packet_serializer #(
        .CLKS_PER_BIT (CPB),
        .MAX_BYTES    (64)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .i_tx_start      (tx_start),
        .i_tx_pid        (tx_pid),
        .i_tx_byte_count (tx_byte_count),
        .i_fifo_data     (fifo_data),
        .i_fifo_empty    (fifo_empty),
        .o_fifo_get_c    (fifo_get),
        .i_crc_in        (crc_in),
        .o_crc_clear_c   (crc_clear),
        .o_crc_enable    (crc_enable),
        .o_crc_invert    (crc_invert),
        .o_serial_out    (serial_out),
        .o_bit_tick      (bit_tick),
        .o_eop           (eop),
        .o_tx_busy       (tx_busy),
        .o_tx_done       (tx_done),
        .o_tx_error_c    (tx_error)
    );

    function automatic logic [15:0] crc_step(input logic [15:0] r, input logic b);
        logic fb;
        fb = r[15] ^ b;
        return {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    // First-word-fall-through FIFO model.
    assign fifo_empty = (fifo_rd == fifo_wr);
    assign fifo_data  = fifo_mem[fifo_rd[3:0]];
    always @(posedge clk) begin
        if (fifo_get) fifo_rd <= fifo_rd + 1;
    end

    // CRC16 generator model driven by the DUT controls.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst)                     crc_rem <= 16'hFFFF;
        else if (crc_clear)             crc_rem <= 16'hFFFF;
        else if (crc_invert)            crc_rem <= ~crc_rem;
        else if (crc_enable && bit_tick) crc_rem <= crc_step(crc_rem, serial_out);
    end
    assign crc_in = crc_rem;

    task automatic check_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int residual(input int from, input int to);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = from; i <= to; i++) r = crc_step(r, rx_mem[i]);
        return int'(r);
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) exp_q.push_back('{eop: 1'b0, ser: b[i], chk: 1'b1});
    endtask

    task automatic push_head(input logic [3:0] pid);
        push_byte(8'h80);
        push_byte({~pid, pid});
    endtask

    task automatic push_eop();
        exp_q.push_back('{eop: 1'b1, ser: 1'b1, chk: 1'b0});
        exp_q.push_back('{eop: 1'b1, ser: 1'b1, chk: 1'b0});
        exp_q.push_back('{eop: 1'b0, ser: 1'b1, chk: 1'b1});
    endtask

    task automatic fifo_load(input logic [7:0] b);
        fifo_mem[fifo_wr[3:0]] = b;
        fifo_wr = fifo_wr + 1;
    endtask

    // Per-cycle observation: event counters and scoreboard pop on each tick.
    task automatic sample_cycle();
        exp_t e;
        if (fifo_get) n_get++;
        if (crc_enable) n_cen++;
        if (crc_enable && bit_tick) n_ctick++;
        if (crc_invert) n_inv++;
        if (tx_error) begin
            n_err++;
            if (bit_tick) n_err_tick++;
        end
        if (tx_done) n_done++;
        if (bit_tick) begin
            if (exp_q.size() == 0) begin
                check_b("unexpected_tick", bit_tick, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_b("eop_at_tick", eop, e.eop);
                if (e.chk) check_b("bit_at_tick", serial_out, e.ser);
            end
            if (!eop && rx_n < 1024) begin
                rx_mem[rx_n] = serial_out;
                rx_n++;
            end
        end
    endtask

    task automatic run_packet(input logic [3:0] pid, input logic [6:0] cnt, input int inj_at);
        n_get = 0; n_cen = 0; n_ctick = 0; n_inv = 0; n_err = 0; n_err_tick = 0; n_done = 0;
        @(negedge clk);
        tx_pid = pid;
        tx_byte_count = cnt;
        tx_start = 1'b1;
        #1;
        check_b("crc_clear_at_start", crc_clear, 1'b1);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        edges = 1;
        check_b("busy_after_start", tx_busy, 1'b1);
        rx_base = rx_n;
        while (edges < 5000) begin
            tx_start = (edges == inj_at);
            if (tx_start) tx_pid = 4'b1010;
            sample_cycle();
            if (tx_done) break;
            @(posedge clk);
            #1;
            edges++;
        end
        tx_start = 1'b0;
        check_b("done_seen", tx_done, 1'b1);
        check_i("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [15:0] ref_rem;
        logic [7:0]  pay [0:1];

        n_rst = 1'b1;
        tx_start = 1'b0;
        tx_pid = 4'b0000;
        tx_byte_count = 7'd0;
        #2;
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_b("rst_serial", serial_out, 1'b1);
        check_b("rst_busy", tx_busy, 1'b0);
        check_b("rst_eop", eop, 1'b0);
        check_b("rst_tick", bit_tick, 1'b0);
        check_b("rst_done", tx_done, 1'b0);
        check_b("rst_crc_en", crc_enable, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(posedge clk);

        // ACK handshake: no payload, no CRC.
        push_head(4'b0010);
        push_eop();
        run_packet(4'b0010, 7'd0, 0);
        check_i("ack_done_time", edges, 19 * CPB + 1);
        check_i("ack_crc_en_cycles", n_cen, 0);
        check_i("ack_fifo_gets", n_get, 0);
        check_i("ack_done_pulses", n_done, 1);
        @(posedge clk);
        #1;
        check_b("ack_busy_fell", tx_busy, 1'b0);
        check_b("ack_done_one_cycle", tx_done, 1'b0);

        // DATA0 with two payload bytes.
        pay[0] = 8'h00;
        pay[1] = 8'h01;
        fifo_load(pay[0]);
        fifo_load(pay[1]);
        push_head(4'b0011);
        ref_rem = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            push_byte(pay[k]);
            for (int i = 0; i < 8; i++) ref_rem = crc_step(ref_rem, pay[k][i]);
        end
        for (int i = 0; i < 16; i++) exp_q.push_back('{eop: 1'b0, ser: ~ref_rem[15 - i], chk: 1'b1});
        push_eop();
        run_packet(4'b0011, 7'd2, 0);
        check_i("d0_done_time", edges, 51 * CPB + 1);
        check_i("d0_fifo_gets", n_get, 2);
        check_i("d0_crc_ticks", n_ctick, 16);
        check_i("d0_crc_inverts", n_inv, 1);
        check_i("d0_errors", n_err, 0);
        check_i("d0_residual", residual(rx_base + 16, rx_n - 2), 32'h800D);
        repeat (2) @(posedge clk);

        // Zero-length DATA1: CRC field is the complement of the initial value.
        push_head(4'b1011);
        for (int i = 0; i < 16; i++) exp_q.push_back('{eop: 1'b0, ser: 1'b0, chk: 1'b1});
        push_eop();
        run_packet(4'b1011, 7'd0, 0);
        check_i("zl_done_time", edges, 35 * CPB + 1);
        check_i("zl_fifo_gets", n_get, 0);
        check_i("zl_crc_ticks", n_ctick, 0);
        check_i("zl_crc_inverts", n_inv, 1);
        check_i("zl_residual", residual(rx_base + 16, rx_n - 2), 32'h800D);
        // Start presented in the tx_done cycle must be dropped.
        tx_pid = 4'b0010;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        check_b("start_on_done_ignored", tx_busy, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check_b("still_idle", tx_busy, 1'b0);

        // Underflow: three bytes requested, only one available.
        fifo_load(8'hA5);
        push_head(4'b0011);
        push_byte(8'hA5);
        push_eop();
        run_packet(4'b0011, 7'd3, 0);
        check_i("uf_errors", n_err, 1);
        check_i("uf_error_on_tick", n_err_tick, 1);
        check_i("uf_fifo_gets", n_get, 1);
        check_i("uf_crc_inverts", n_inv, 0);
        check_i("uf_done_pulses", n_done, 1);
        check_i("uf_done_time", edges, 27 * CPB + 1);
        repeat (2) @(posedge clk);

        // Reset during the first payload byte.
        fifo_load(8'h3C);
        fifo_load(8'hC3);
        @(negedge clk);
        tx_pid = 4'b0011;
        tx_byte_count = 7'd2;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (fifo_get) break;
            @(posedge clk);
            #1;
        end
        check_b("rst_test_first_get", fifo_get, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_b("mid_rst_busy", tx_busy, 1'b0);
        check_b("mid_rst_serial", serial_out, 1'b1);
        check_b("mid_rst_eop", eop, 1'b0);
        check_b("mid_rst_get", fifo_get, 1'b0);
        check_b("mid_rst_inv", crc_invert, 1'b0);
        check_b("mid_rst_crc_en", crc_enable, 1'b0);
        check_b("mid_rst_done", tx_done, 1'b0);
        repeat (2) @(posedge clk);
        fifo_wr = fifo_rd;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(posedge clk);

        // Normal ACK after reset, with a stray start while busy.
        push_head(4'b0010);
        push_eop();
        run_packet(4'b0010, 7'd0, 40);
        check_i("post_rst_done_time", edges, 19 * CPB + 1);
        check_i("post_rst_crc_en", n_cen, 0);
        repeat (30) @(posedge clk);
        #1;
        check_b("busy_start_ignored", tx_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
